// File: rtl/gate_pkg.sv
// gate_pkg: shared op encodings, FSM states and vector-index width for gate_tester
package gate_pkg;
  localparam int IDX_W = 2;
  typedef enum logic [2:0] {OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR} op_t;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
  function automatic logic op_valid(input logic [2:0] op);
    return !(op[2] && op[1]);
  endfunction
endpackage

// File: rtl/gate_ref.sv
// gate_ref: golden two-input gate model selected by op
module gate_ref
  import gate_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       expected
);
  always_comb begin
    expected = 1'b0;
    case (op)
      OP_AND:  expected = a & b;
      OP_OR:   expected = a | b;
      OP_XOR:  expected = a ^ b;
      OP_NAND: expected = ~(a & b);
      OP_NOR:  expected = ~(a | b);
      OP_XNOR: expected = ~(a ^ b);
      default: expected = 1'b0;
    endcase
  end
endmodule

// File: rtl/gate_tester.sv
// gate_tester: drives all four {a,b} vectors into a gate under test and scores its response
module gate_tester
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] first_fail
);
  state_t state, nxt;
  logic [IDX_W-1:0] idx;
  logic [3:0] cnt;
  logic [2:0] op_q;
  logic exp_y, mism;
  gate_ref u_ref (.op(op_q), .a(a), .b(b), .expected(exp_y));
  assign mism = exp_y != y;
  assign busy = state inside {DRIVE, SETTLE, CHECK};
  assign done = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start && op_valid(op) ? DRIVE : IDLE;
      DRIVE:   nxt = SETTLE;
      SETTLE:  nxt = cnt == 4'd0 ? CHECK : SETTLE;
      CHECK:   nxt = idx == 2'd3 ? DONE : DRIVE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      op_q <= '0;
      a <= 1'b0;
      b <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == DRIVE) begin
        op_q <= op;
        idx <= '0;
        pass <= 1'b0;
        err_count <= '0;
        fail_valid <= 1'b0;
        first_fail <= '0;
      end
      if (state == DRIVE) begin
        {a, b} <= idx;
        cnt <= 4'(SETTLE_CYCLES - 1);
      end
      if (state == SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == CHECK) begin
        if (mism) begin
          err_count <= err_count + 3'(err_count != 3'd4);
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            first_fail <= idx;
          end
        end
        if (idx == 2'd3) pass <= err_count == 3'd0 && !mism;
        else idx <= idx + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_gate_tester.sv
// tb_gate_tester: table-driven scoreboard bench for gate_tester with a modelled gate under test
module tb_gate_tester;
  import gate_pkg::*;
  typedef struct {
    logic [2:0] op;
    logic [2:0] mode;
    logic [2:0] err;
    logic       fv;
    logic [1:0] ff;
    logic       pass;
  } vec_t;
  typedef struct {
    logic [2:0] err;
    logic       fv;
    logic [1:0] ff;
    logic       pass;
  } res_t;
  logic clk = 1'b0;
  logic rst, start, a, b, y, busy, done, pass, fail_valid;
  logic [2:0] op, mode, err_count;
  logic [1:0] first_fail;
  int checks = 0, errors = 0;
  res_t sb[$];
  res_t r;
  vec_t tbl[12];
  always #5 clk = ~clk;
  gate_tester #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail(first_fail)
  );
  function automatic logic gut(input logic [2:0] m, input logic ai, input logic bi);
    case (m)
      3'd0: return ai & bi;
      3'd1: return ai | bi;
      3'd2: return ai ^ bi;
      3'd3: return ~(ai & bi);
      3'd4: return ~(ai | bi);
      3'd5: return ~(ai ^ bi);
      3'd6: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction
  assign y = gut(mode, a, b);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        r = sb.pop_front();
        chk("err_count", err_count, r.err);
        chk("fail_valid", fail_valid, r.fv);
        chk("pass", pass, r.pass);
        if (r.fv) chk("first_fail", first_fail, r.ff);
      end
    end
  end
  task automatic run(input logic [2:0] o, input logic [2:0] m, input res_t e, input bit disturb, input string tag);
    int n;
    bit got;
    mode = m;
    op = o;
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    got = 0;
    chk({tag, "_busy"}, busy, 1);
    while (!got && n < 60) begin
      if (done) got = 1;
      else begin
        if (disturb) begin
          start = (n % 3 == 0) && n < 16;
          op = 3'(n);
        end
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    op = o;
    if (!got) void'(sb.pop_back());
    chk({tag, "_latency"}, got ? n : -1, 17);
    chk({tag, "_ab_done"}, {a, b}, 3);
    @(negedge clk);
    chk({tag, "_ab_idle"}, {a, b}, 3);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_pass_held"}, pass, e.pass);
  endtask
  initial begin
    int busy_seen;
    logic [8:0] saved;
    rst = 1'b1;
    start = 1'b0;
    op = 3'd0;
    mode = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ab", {a, b}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fv", fail_valid, 0);
    chk("rst_ff", first_fail, 0);
    tbl[0]  = '{OP_AND,  3'd0, 3'd0, 1'b0, 2'd0, 1'b1};
    tbl[1]  = '{OP_XOR,  3'd1, 3'd1, 1'b1, 2'd3, 1'b0};
    tbl[2]  = '{OP_NAND, 3'd6, 3'd3, 1'b1, 2'd0, 1'b0};
    tbl[3]  = '{OP_OR,   3'd1, 3'd0, 1'b0, 2'd0, 1'b1};
    tbl[4]  = '{OP_NOR,  3'd7, 3'd3, 1'b1, 2'd1, 1'b0};
    tbl[5]  = '{OP_NAND, 3'd3, 3'd0, 1'b0, 2'd0, 1'b1};
    tbl[6]  = '{OP_XOR,  3'd2, 3'd0, 1'b0, 2'd0, 1'b1};
    tbl[7]  = '{OP_AND,  3'd7, 3'd3, 1'b1, 2'd0, 1'b0};
    tbl[8]  = '{OP_NOR,  3'd4, 3'd0, 1'b0, 2'd0, 1'b1};
    tbl[9]  = '{OP_OR,   3'd0, 3'd2, 1'b1, 2'd1, 1'b0};
    tbl[10] = '{OP_XNOR, 3'd4, 3'd1, 1'b1, 2'd3, 1'b0};
    tbl[11] = '{OP_XNOR, 3'd2, 3'd4, 1'b1, 2'd0, 1'b0};
    for (int i = 0; i < 12; i++)
      run(tbl[i].op, tbl[i].mode, '{tbl[i].err, tbl[i].fv, tbl[i].ff, tbl[i].pass}, 0, $sformatf("vec%0d", i));
    saved = {a, b, pass, err_count, fail_valid, first_fail};
    busy_seen = 0;
    for (int k = 0; k < 2; k++) begin
      op = 3'd6 + 3'(k);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (busy || done) busy_seen++;
        @(negedge clk);
      end
    end
    chk("reserved_busy", busy_seen, 0);
    chk("reserved_hold", {a, b, pass, err_count, fail_valid, first_fail}, saved);
    run(OP_AND, 3'd0, '{3'd0, 1'b0, 2'd0, 1'b1}, 1, "disturb");
    run(OP_NAND, 3'd6, '{3'd3, 1'b1, 2'd0, 1'b0}, 0, "pre_rst");
    mode = 3'd7;
    op = OP_AND;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("midrun_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", {a, b, busy, done, pass, err_count, fail_valid, first_fail}, 0);
    repeat (20) @(negedge clk);
    chk("midrst_idle", {busy, err_count}, 0);
    run(OP_XOR, 3'd6, '{3'd2, 1'b1, 2'd1, 1'b0}, 0, "post_rst");
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
